uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BAUD, default 1250, clk cycles per bit period; legal range 4..2047.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_serial  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port rx_byte  output  8  last received data byte; holds value between frames.
REQ-006 SHALL have port rx_ready  output  1  single-cycle pulse; rx_byte, parity_err and frame_err are valid in that cycle.
REQ-007 SHALL have port parity_err  output  1  even-parity mismatch on the last frame.
REQ-008 SHALL have port frame_err  output  1  stop bit sampled low on the last frame.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL accept frames of: start(0), 8 data bits LSB first, parity bit, stop(1), each CLKS_PER_BAUD cycles long.
REQ-011 SHALL treat the parity bit as correct when XOR of the 8 data bits XOR parity bit equals 0 (even parity).
REQ-012 SHALL pass rx_serial through a 2-flop synchronizer; all decisions use the synchronized value rx_sync.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE and WAIT_HIGH.
REQ-014 IDLE: on rx_sync==0, SHALL go to START with clk_count=0; otherwise SHALL stay in IDLE.
REQ-015 START: SHALL count to (CLKS_PER_BAUD-1)/2 (integer division) and sample there; if 0, go to DATA with clk_count=0 and bit_index=0; if 1, treat as a glitch and return to IDLE.
REQ-016 DATA: SHALL sample when clk_count reaches CLKS_PER_BAUD-1 (mid-bit), store the sample at rx bit_index, and reset clk_count; after bit_index 7, go to PARITY.
REQ-017 PARITY: SHALL sample at CLKS_PER_BAUD-1, compute the parity error, then go to STOP.
REQ-018 STOP: SHALL sample at CLKS_PER_BAUD-1, record frame error = (sample==0), then go to DONE.
REQ-019 DONE: lasts one cycle.
 - rx_ready=1; rx_byte, parity_err and frame_err update together in this cycle.
 - Next state: WAIT_HIGH if frame error, else IDLE.
REQ-020 WAIT_HIGH: SHALL stay until rx_sync==1, then go to IDLE; a held-low (break) line SHALL NOT produce further frames.
REQ-021 rx_byte, parity_err and frame_err SHALL change only in DONE or on reset.
REQ-022 clk_count SHALL be $clog2(CLKS_PER_BAUD) bits wide and SHALL never exceed CLKS_PER_BAUD-1.
REQ-023 SHALL receive back-to-back frames: a start bit beginning immediately after a valid stop bit SHALL be detected via IDLE.

Reset
REQ-024 On nRst low, SHALL go to IDLE with clk_count=0, bit_index=0 and the shift register=0.
REQ-025 On nRst low, synchronizer flops SHALL reset to 1.
REQ-026 On nRst low, rx_byte=0x00, rx_ready=0, parity_err=0, frame_err=0 and busy=0, immediately and asynchronously.
REQ-027 Reset mid-frame SHALL abandon the frame with no rx_ready pulse.

Structure
REQ-028 Package uart_pkg SHALL hold the rx_state_t enum and the default baud constant, shared with the transmitter.
REQ-029 The synchronizer SHALL be a sub-module uart_rx_sync (2-flop, reset value 1); all other logic lives in uart_rx.

Verification (CLKS_PER_BAUD=16)
REQ-030 Drive frame 0xA5, parity 0, stop 1 -> exactly one rx_ready pulse; rx_byte=0xA5, parity_err=0, frame_err=0; busy high for the whole frame.
REQ-031 Drive 0x07 with parity bit 0 (correct value is 1) -> rx_byte=0x07, parity_err=1, frame_err=0.
REQ-032 Drive 0x3C with stop bit 0, then hold the line low for 40 cycles, then high -> frame_err=1; stays in WAIT_HIGH with no second rx_ready; next frame 0x11 is received cleanly.
REQ-033 Drive a low glitch of 4 cycles on an idle line -> returns to IDLE, no rx_ready, outputs unchanged.
REQ-034 Assert nRst during DATA bit 3 -> all outputs 0, no rx_ready; subsequent 0x5A is received correctly.
REQ-035 Drive back-to-back 0x00 then 0xFF with no idle gap -> two rx_ready pulses 11*16 cycles apart (±1), values correct, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BAUD = 1250;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic nRst,
  input  logic serial,
  output logic sync
);

  logic meta;

  // NOTE: clocked state uses non-blocking assignments so both flops sample the old values on the same edge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= serial;
      sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop; mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int            CW   = $clog2(CLKS_PER_BAUD);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BAUD - 1) / 2);

  logic          rx_sync;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    index_q, index_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_pend_q, par_pend_d;
  logic [7:0]    byte_d;
  logic          perr_d, ferr_d;

  uart_rx_sync u_sync (
    .clk    (clk),
    .nRst   (nRst),
    .serial (rx_serial),
    .sync   (rx_sync)
  );

  // The visible results are loaded on the edge into DONE so they are valid with the pulse.
  assign rx_ready = (state_q == DONE);
  assign busy     = (state_q != IDLE);

  // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    byte_d     = rx_byte;
    perr_d     = parity_err;
    ferr_d     = frame_err;

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (count_q == HALF) begin
          count_d = '0;
          if (!rx_sync) begin
            state_d = DATA;
            index_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DATA: begin
        if (count_q == LAST) begin
          count_d          = '0;
          shift_d[index_q] = rx_sync;
          if (index_q == 3'd7) state_d = PARITY;
          else                 index_d = index_q + 3'd1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      PARITY: begin
        if (count_q == LAST) begin
          count_d    = '0;
          par_pend_d = (^shift_q) ^ rx_sync;
          state_d    = STOP;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      STOP: begin
        if (count_q == LAST) begin
          count_d = '0;
          byte_d  = shift_q;
          perr_d  = par_pend_q;
          ferr_d  = !rx_sync;
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        // A low stop bit may be a break; wait for the line to recover before hunting again.
        state_d = frame_err ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      index_q    <= '0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      rx_byte    <= 8'h00;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      shift_q    <= shift_d;
      par_pend_q <= par_pend_d;
      rx_byte    <= byte_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       nRst;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } result_t;

  result_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int ready_count = 0;
  int last_ready = 0;
  int prev_ready = 0;
  int frames_sent = 0;

  uart_rx #(.CLKS_PER_BAUD(CPB)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .rx_serial  (rx_serial),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected result of one frame, straight from the frame rules.
  function automatic result_t model(input logic [7:0] d, input logic p, input logic s);
    result_t r;
    r.data = d;
    r.perr = ((^d) ^ p) != 1'b0;
    r.ferr = (s == 1'b0);
    return r;
  endfunction

  // Scoreboard: every rx_ready pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (rx_ready === 1'b1) begin
      result_t e;
      ready_count++;
      prev_ready = last_ready;
      last_ready = cycle;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", rx_byte, e.data);
        check("parity_err", parity_err, e.perr);
        check("frame_err", frame_err, e.ferr);
      end
    end
  end

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Leaves the stop-bit level on the line afterwards.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit check_busy);
    logic [10:0] f;
    bit busy_ok;
    f = {s, p, d, 1'b0};
    busy_ok = 1'b1;
    exp_q.push_back(model(d, p, s));
    frames_sent++;
    for (int i = 0; i < 11; i++) begin
      rx_serial = f[i];
      repeat (CPB / 2) @(negedge clk);
      if (check_busy) busy_ok = busy_ok & (busy === 1'b1);
      repeat (CPB / 2) @(negedge clk);
    end
    if (check_busy) check("busy_frame", busy_ok, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sv_byte;
    logic       sv_perr, sv_ferr;
    int         rc0;
    logic [7:0] d;
    logic       p, s;

    nRst      = 1'b0;
    rx_serial = 1'b1;
    #1;
    check("rst_byte", rx_byte, 8'h00);
    check("rst_ready", rx_ready, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    nRst = 1'b1;
    idle(32);

    // Clean frame with busy observed across every bit.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    idle(32);
    drain();
    check("a5_count", ready_count, 1);

    // Wrong parity bit.
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    idle(32);
    drain();

    // Low stop bit followed by a held-low break.
    rc0 = ready_count;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy", busy, 1'b1);
    check("break_one_ready", ready_count - rc0, 1);
    idle(48);
    check("break_released", busy, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    idle(32);
    drain();

    // Short low glitch on an idle line.
    sv_byte = rx_byte;
    sv_perr = parity_err;
    sv_ferr = frame_err;
    rc0     = ready_count;
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_ready", ready_count, rc0);
    check("glitch_byte", rx_byte, sv_byte);
    check("glitch_perr", parity_err, sv_perr);
    check("glitch_ferr", frame_err, sv_ferr);
    check("glitch_busy", busy, 1'b0);

    // Reset during data bit 3.
    rc0 = ready_count;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_serial = i[0];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    nRst = 1'b0;
    #1;
    check("mid_rst_byte", rx_byte, 8'h00);
    check("mid_rst_ready", rx_ready, 1'b0);
    check("mid_rst_perr", parity_err, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    idle(32);
    check("mid_rst_no_ready", ready_count, rc0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle(32);
    drain();

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(32);
    drain();
    check("b2b_gap_ok", (last_ready - prev_ready >= 11 * CPB - 1) &&
                        (last_ready - prev_ready <= 11 * CPB + 1), 1'b1);

    // Random frames: random data, occasional bad parity or low stop bit.
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      s = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      send_frame(d, p, s, 1'b0);
      idle(int'($urandom_range(16, 40)));
      drain();
    end

    check("ready_total", ready_count, frames_sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
